uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLK_HZ, default 80_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bit count; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, TX FIFO entries; power of two, 2..16.
REQ-007 SHALL have port sys_clk_i, input, 1, system clock; all state updates on falling edge.
REQ-008 SHALL have port sys_rst_i, input, 1, reset, asynchronous, active-high.
REQ-009 SHALL have port uart_wr_i, input, 1, write strobe; one byte accepted per cycle when high and uart_ready_o is high.
REQ-010 SHALL have port uart_dat_i, input, DATA_BITS, payload to send, LSB first.
REQ-011 SHALL have port uart_ready_o, output, 1, high when a write would be accepted this cycle.
REQ-012 SHALL have port uart_busy_o, output, 1, high while the shifter is not IDLE or the FIFO is non-empty.
REQ-013 SHALL have port uart_ovf_o, output, 1, one-cycle pulse when uart_wr_i is high while uart_ready_o is low; the data is dropped.
REQ-014 SHALL have port fifo_level_o, output, $clog2(FIFO_DEPTH+1), number of queued words not yet loaded into the shifter.
REQ-015 SHALL have port uart_tx, output, 1, serial line, idle high.

Function
REQ-016 SHALL generate bit timing with a fractional accumulator: each cycle acc += BAUD; when acc >= CLK_HZ, acc -= CLK_HZ and a one-cycle tick is asserted.
REQ-017 SHALL hold the accumulator at 0 in IDLE, so the start bit always lasts a full bit period.
REQ-018 SHALL size the accumulator as $clog2(CLK_HZ+BAUD)+1 bits; no wrap-around is permitted.
REQ-019 SHALL implement the states IDLE, START, DATA, PAR, STOP.
REQ-020 SHALL, in IDLE with a word available, load the shifter, enter START and drive uart_tx low on the next edge.
REQ-021 SHALL advance state only on tick: START->DATA; DATA shifts LSB first for DATA_BITS ticks; DATA->PAR if PARITY!=0, else DATA->STOP; PAR->STOP; STOP lasts STOP_BITS ticks, then goes to IDLE.
REQ-022 SHALL drive the parity bit as the XOR of the payload for even parity and its inversion for odd parity.
REQ-023 SHALL allow back-to-back frames: if a word is available at STOP exit, go directly to START with no idle gap.
REQ-024 SHALL count one frame as 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods.
REQ-025 SHALL NOT alter the frame in flight when uart_wr_i arrives mid-frame; the word is queued or dropped.
REQ-026 SHALL, when a write and a shifter load coincide on a full FIFO, accept the write: uart_ready_o reflects the pop in that same cycle.

Reset
REQ-027 SHALL, while sys_rst_i is high, force uart_tx=1, state=IDLE, acc=0, FIFO empty, fifo_level_o=0, uart_busy_o=0, uart_ovf_o=0 and uart_ready_o=1.
REQ-028 SHALL, if reset is asserted mid-frame, abort the frame immediately, return uart_tx high and discard all queued words.

Configuration
REQ-029 SHALL use the macro UART_TX_FIFO_EN to enable the FIFO_DEPTH-entry circular FIFO between the write port and the shifter, with wrapping read/write pointers.
REQ-030 SHALL, with UART_TX_FIFO_EN undefined, use a single holding register instead: uart_ready_o = (state==IDLE), fifo_level_o tied to 0 and FIFO_DEPTH ignored.

Verification
REQ-031 SHALL verify with CLK_HZ=1_000_000, BAUD=100_000, 8N1: write 0xA5 -> uart_tx low for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high for 10 cycles; uart_busy_o drops after 100 cycles.
REQ-032 SHALL verify with PARITY=2, DATA_BITS=7: write 0x41 -> parity bit 0; with PARITY=1 -> parity bit 1; STOP_BITS=2 -> stop high for 20 cycles.
REQ-033 SHALL verify with the FIFO enabled, depth 4: 6 consecutive writes during idle -> 5 accepted (1 loaded into the shifter plus 4 queued), 1 uart_ovf_o pulse, and 5 back-to-back frames with no idle gap.
REQ-034 SHALL verify reset asserted at cycle 35 of a frame -> uart_tx=1 within the same cycle, fifo_level_o=0, and no residual bits after reset release.
REQ-035 SHALL verify CLK_HZ=80_000_000, BAUD=115200: 1000 consecutive bit periods total 694444 +/- 1 cycles, with no accumulator overflow.
REQ-036 SHALL verify with the FIFO disabled: a write during a frame -> uart_ovf_o pulse, and the frame in flight is unchanged.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter, fractional-accumulator baud timing, falling-edge state.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register is used.
module uart_tx_param #(
  parameter int unsigned CLK_HZ     = 80_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             sys_clk_i,
  input  logic                             sys_rst_i,
  input  logic                             uart_wr_i,
  input  logic [DATA_BITS-1:0]             uart_dat_i,
  output logic                             uart_ready_o,
  output logic                             uart_busy_o,
  output logic                             uart_ovf_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
  output logic                             uart_tx
);

  localparam int unsigned ACC_W = $clog2(CLK_HZ + BAUD) + 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d, sum_c;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;

  logic                   tick_c;
  logic                   avail_c;
  logic                   load_c;
  logic                   rdy_c;
  logic                   wr_ok_c;
  logic [DATA_BITS-1:0]   head_c;

  // Baud tick: accumulator advances by BAUD, wraps by CLK_HZ; idle keeps it parked at zero.
  assign sum_c  = acc_q + ACC_W'(BAUD);
  assign tick_c = (state_q != S_IDLE) && (sum_c >= ACC_W'(CLK_HZ));

  // A word is taken from the queue when idle, or straight out of the final stop bit.
  assign load_c  = avail_c && ((state_q == S_IDLE) ||
                               ((state_q == S_STOP) && tick_c && (cnt_q == LAST_STOP)));
  assign wr_ok_c = uart_wr_i && rdy_c;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     lvl_q, lvl_d;

  assign avail_c      = (lvl_q != '0);
  assign head_c       = mem_q[rd_ptr_q];
  assign rdy_c        = (lvl_q != LVL_W'(FIFO_DEPTH)) || load_c;
  assign fifo_level_o = lvl_q;

  // Power-of-two depth lets the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (load_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_ok_c && !load_c)      lvl_d = lvl_q + LVL_W'(1);
    else if (!wr_ok_c && load_c) lvl_d = lvl_q - LVL_W'(1);
  end

  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

  always_ff @(negedge sys_clk_i) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= uart_dat_i;
  end
`else
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;

  assign avail_c      = hold_vld_q;
  assign head_c       = hold_q;
  assign rdy_c        = (state_q == S_IDLE);
  assign fifo_level_o = '0;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (load_c) hold_vld_d = 1'b0;
    if (wr_ok_c) begin
      hold_d     = uart_dat_i;
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end
`endif

  // State register.
  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (avail_c) state_d = S_START;
      S_START: if (tick_c) state_d = S_DATA;
      S_DATA:  if (tick_c && (cnt_q == LAST_DATA)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (tick_c) state_d = S_STOP;
      S_STOP:  if (tick_c && (cnt_q == LAST_STOP)) state_d = avail_c ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and line output; tx is computed from the next state so it changes on the same edge.
  always_comb begin
    acc_d   = tick_c ? (sum_c - ACC_W'(CLK_HZ)) : sum_c;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = 1'b1;
    ovf_d   = uart_wr_i && !rdy_c;

    if ((state_q == S_IDLE) || (state_d == S_IDLE)) acc_d = '0;

    if (state_d != state_q)                 cnt_d = '0;
    else if (tick_c)                        cnt_d = cnt_q + CNT_W'(1);

    if (load_c) begin
      shift_d = head_c;
      par_d   = (PARITY == 1) ? ~(^head_c) : ^head_c;
    end else if (tick_c && (state_q == S_DATA)) begin
      shift_d = shift_q >> 1;
    end

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(negedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_tx      = tx_q;
  assign uart_ovf_o   = ovf_q;
  assign uart_ready_o = rdy_c;
  assign uart_busy_o  = (state_q != S_IDLE) || avail_c;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame shapes, parity, stop bits, overflow, reset abort and baud accuracy.
// FIFO-specific steps are included when UART_TX_FIFO_EN is defined.
module tb_uart_tx_param;

  localparam longint F_CLK  = 80_000_000;
  localparam longint F_BAUD = 115200;

  logic       clk;
  logic       rst;
  logic       wr_a, wr_b, wr_c, wr_f;
  logic [7:0] dat_a, dat_f;
  logic [6:0] dat_b, dat_c;
  logic       rdy_a, rdy_b, rdy_c, rdy_f;
  logic       busy_a, busy_b, busy_c, busy_f;
  logic       ovf_a, ovf_b, ovf_c, ovf_f;
  logic [2:0] lvl_a, lvl_b, lvl_c, lvl_f;
  logic       tx_a, tx_b, tx_c, tx_f;

  int checks = 0;
  int errors = 0;

  logic ovf_seen, rdy_seen, ovf_after;
  int   eidx [16];
  int   nedge, end_n, highs, falls, inj;
  logic prev;

  uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_a), .uart_dat_i(dat_a),
    .uart_ready_o(rdy_a), .uart_busy_o(busy_a), .uart_ovf_o(ovf_a),
    .fifo_level_o(lvl_a), .uart_tx(tx_a));

  uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_b), .uart_dat_i(dat_b),
    .uart_ready_o(rdy_b), .uart_busy_o(busy_b), .uart_ovf_o(ovf_b),
    .fifo_level_o(lvl_b), .uart_tx(tx_b));

  uart_tx_param #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_c), .uart_dat_i(dat_c),
    .uart_ready_o(rdy_c), .uart_busy_o(busy_c), .uart_ovf_o(ovf_c),
    .fifo_level_o(lvl_c), .uart_tx(tx_c));

  uart_tx_param #(.CLK_HZ(80_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_f (
    .sys_clk_i(clk), .sys_rst_i(rst), .uart_wr_i(wr_f), .uart_dat_i(dat_f),
    .uart_ready_o(rdy_f), .uart_busy_o(busy_f), .uart_ovf_o(ovf_f),
    .fifo_level_o(lvl_f), .uart_tx(tx_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int i);
    case (i)
      0:       return tx_a;
      1:       return tx_b;
      2:       return tx_c;
      default: return tx_f;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0:       return busy_a;
      1:       return busy_b;
      2:       return busy_c;
      default: return busy_f;
    endcase
  endfunction

  // Cycle index of the k-th bit boundary when the accumulator starts at zero.
  function automatic int bit_edge(input int k);
    return int'((longint'(k) * F_CLK + F_BAUD - 1) / F_BAUD);
  endfunction

  task automatic send(input int i, input logic [7:0] d);
    @(posedge clk);
    case (i)
      0:       begin wr_a = 1'b1; dat_a = d;      end
      1:       begin wr_b = 1'b1; dat_b = d[6:0]; end
      2:       begin wr_c = 1'b1; dat_c = d[6:0]; end
      default: begin wr_f = 1'b1; dat_f = d;      end
    endcase
    @(posedge clk);
    wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0; wr_f = 1'b0;
  endtask

  // Checks every cycle of each bit; optionally fires a write into u_a at frame cycle inj.
  task automatic check_frame(input int i, input logic [15:0] bits, input int nbits,
                             input int per, input int inj_cyc);
    int good;
    int cyc;
    cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      good = 0;
      for (int c = 0; c < per; c++) begin
        @(posedge clk);
        if (tx_of(i) === bits[b]) good++;
        if (inj_cyc >= 0) begin
          if (cyc == inj_cyc) begin
            rdy_seen = rdy_a;
            wr_a = 1'b1;
            dat_a = 8'h3C;
          end else if (cyc == inj_cyc + 1) begin
            ovf_seen = ovf_a;
            wr_a = 1'b0;
          end else if (cyc == inj_cyc + 2) begin
            ovf_after = ovf_a;
          end
        end
        cyc++;
      end
      chk($sformatf("frame%0d_bit%0d", i, b), good, per);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0; wr_f = 1'b0;
    dat_a = '0; dat_b = '0; dat_c = '0; dat_f = '0;
    ovf_seen = 1'b0; rdy_seen = 1'b1; ovf_after = 1'b0;
    for (int k = 0; k < 16; k++) eidx[k] = -1;

    // Reset state.
    repeat (3) @(posedge clk);
    chk("rst_tx", tx_a, 1);
    chk("rst_ready", rdy_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_level", lvl_a, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 8N1 0xA5; without the FIFO a mid-frame write must overflow and leave the frame alone.
`ifdef UART_TX_FIFO_EN
    inj = -1;
`else
    inj = 35;
`endif
    send(0, 8'hA5);
    check_frame(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 10, inj);
`ifndef UART_TX_FIFO_EN
    chk("midframe_ready", rdy_seen, 0);
    chk("midframe_ovf_pulse", ovf_seen, 1);
    chk("midframe_ovf_clear", ovf_after, 0);
`endif
    chk("a_busy_in_stop", busy_a, 1);
    @(posedge clk);
    chk("a_busy_done", busy_a, 0);
    chk("a_tx_idle", tx_a, 1);
    repeat (15) @(posedge clk);
    chk("a_no_extra_frame", {31'd0, busy_a | ~tx_a}, 0);

    // 7E1 and 7O2 with payload 0x41.
    send(1, 8'h41);
    check_frame(1, 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 10, -1);
    @(posedge clk);
    chk("b_busy_done", busy_of(1), 0);

    send(2, 8'h41);
    check_frame(2, 16'({1'b1, 1'b1, 1'b1, 7'h41, 1'b0}), 11, 10, -1);
    @(posedge clk);
    chk("c_busy_done", busy_of(2), 0);

    // 80 MHz / 115200: 0x55 toggles at every bit boundary.
    send(3, 8'h55);
    nedge = 0;
    end_n = -1;
    prev  = 1'b0;
    @(posedge clk);
    chk("f_start_low", tx_f, 0);
    for (int n = 1; n < 8000; n++) begin
      @(posedge clk);
      if (tx_f !== prev) begin
        if (nedge < 16) eidx[nedge] = n;
        nedge++;
        prev = tx_f;
      end
      if (!busy_f) begin
        end_n = n;
        break;
      end
    end
    chk("f_edge_count", nedge, 9);
    for (int k = 1; k <= 9; k++) chk($sformatf("f_boundary%0d", k), eidx[k-1], bit_edge(k));
    chk("f_frame_len", end_n, bit_edge(10));

    // Reset in the middle of an all-zero frame.
    send(0, 8'h00);
`ifdef UART_TX_FIFO_EN
    send(0, 8'h00);
`endif
    repeat (35) @(posedge clk);
    chk("pre_rst_tx_low", tx_a, 0);
`ifdef UART_TX_FIFO_EN
    chk("pre_rst_level", lvl_a, 1);
`endif
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx", tx_a, 1);
    chk("midrst_level", lvl_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ready", rdy_a, 1);
    @(posedge clk);
    rst = 1'b0;
    highs = 0;
    for (int n = 0; n < 120; n++) begin
      @(posedge clk);
      if (tx_a === 1'b1 && busy_a === 1'b0) highs++;
    end
    chk("post_rst_quiet", highs, 120);

`ifdef UART_TX_FIFO_EN
    // Six writes from idle: one loaded, four queued, one dropped; five frames back to back.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      wr_a  = 1'b1;
      dat_a = 8'hFF;
    end
    @(posedge clk);
    wr_a = 1'b0;
    chk("fifo_ovf_pulse", ovf_a, 1);
    chk("fifo_level_full", lvl_a, 4);
    chk("fifo_ready_full", rdy_a, 0);
    prev  = tx_a;
    falls = 0;
    end_n = -1;
    for (int n = 7; n < 1000; n++) begin
      @(posedge clk);
      if (n == 7) chk("fifo_ovf_clear", ovf_a, 0);
      if (prev === 1'b1 && tx_a === 1'b0) falls++;
      prev = tx_a;
      if (!busy_a) begin
        end_n = n;
        break;
      end
    end
    chk("fifo_extra_starts", falls, 4);
    chk("fifo_b2b_end", end_n, 502);
    chk("fifo_level_empty", lvl_a, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
